// File: rtl/bcd_counter_multi_if.sv
// Bus bundle for bcd_counter_multi: control/load inputs from the controller,
// count, flags and display drive back from the counter.
interface bcd_counter_multi_if #(
   parameter int DIGITS = 4
);
   logic                  en;
   logic                  up;
   logic                  Load;
   logic [4*DIGITS-1:0]   Din;
   logic [4*DIGITS-1:0]   Q;
   logic                  tc;
   logic                  load_err;
   logic [6:0]            seg;
   logic [DIGITS-1:0]     dig_sel;

   modport master (
      output en, up, Load, Din,
      input  Q, tc, load_err, seg, dig_sel
   );

   modport slave (
      input  en, up, Load, Din,
      output Q, tc, load_err, seg, dig_sel
   );
endinterface

// File: rtl/bcd_counter_multi.sv
// Multi-digit BCD up/down counter with validated parallel load, wrap/saturate
// limits, cascade terminal count and a multiplexed 7-segment scan driver.
module bcd_counter_multi #(
   parameter int DIGITS       = 4,
   parameter int SCAN_DIV     = 4,
   parameter int SATURATE     = 0,
   parameter int COMMON_ANODE = 0
) (
   input logic                clk,
   input logic                rst_asyn,
   bcd_counter_multi_if.slave bus
);

   localparam int W  = 4 * DIGITS;
   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [6:0]        SEG_RST = (COMMON_ANODE != 0) ? ~7'h3F : 7'h3F;
   localparam logic [DIGITS-1:0] SEL_RST = (COMMON_ANODE != 0) ? ~DIGITS'(1) : DIGITS'(1);

   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   logic [W-1:0]      count_q;
   logic [W-1:0]      count_inc;
   logic [W-1:0]      count_dec;
   logic [W-1:0]      count_next;
   logic              load_err_q;
   logic              all_nine;
   logic              all_zero;
   logic              din_ok;
   logic              carry;
   logic              borrow;
   logic [3:0]        digit;

   logic [PW-1:0]     prescaler;
   logic [PW-1:0]     prescaler_next;
   logic              pre_wrap;
   logic [IW-1:0]     idx;
   logic [IW-1:0]     idx_next;
   logic [3:0]        scan_digit;
   logic [6:0]        seg_q;
   logic [DIGITS-1:0] sel_q;

   // Ripple carry/borrow across digits: a digit moves only when every lower
   // digit is at its rollover value, which keeps every digit inside 0..9.
   always_comb begin
      all_nine  = 1'b1;
      all_zero  = 1'b1;
      din_ok    = 1'b1;
      carry     = 1'b1;
      borrow    = 1'b1;
      count_inc = count_q;
      count_dec = count_q;
      digit     = 4'd0;
      for (int k = 0; k < DIGITS; k++) begin
         digit = count_q[4*k +: 4];
         if (digit != 4'd9) all_nine = 1'b0;
         if (digit != 4'd0) all_zero = 1'b0;
         if (bus.Din[4*k +: 4] > 4'd9) din_ok = 1'b0;
         if (carry) begin
            if (digit == 4'd9) begin
               count_inc[4*k +: 4] = 4'd0;
            end else begin
               count_inc[4*k +: 4] = digit + 4'd1;
               carry = 1'b0;
            end
         end
         if (borrow) begin
            if (digit == 4'd0) begin
               count_dec[4*k +: 4] = 4'd9;
            end else begin
               count_dec[4*k +: 4] = digit - 4'd1;
               borrow = 1'b0;
            end
         end
      end
   end

   always_comb begin
      count_next = count_q;
      if (bus.Load) begin
         if (din_ok) count_next = bus.Din;
      end else if (bus.en) begin
         if (bus.up) begin
            if (!(all_nine && SATURATE != 0)) count_next = count_inc;
         end else begin
            if (!(all_zero && SATURATE != 0)) count_next = count_dec;
         end
      end
   end

   // Scan position runs free of the counter; the digit shown is picked with
   // the post-update index so seg and dig_sel always describe the same digit.
   always_comb begin
      pre_wrap       = (prescaler == PW'(SCAN_DIV - 1));
      prescaler_next = pre_wrap ? '0 : prescaler + 1'b1;
      idx_next       = idx;
      if (pre_wrap) idx_next = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      scan_digit = 4'd0;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx_next == IW'(k)) scan_digit = count_q[4*k +: 4];
      end
   end

   always_ff @(posedge clk or posedge rst_asyn) begin
      if (rst_asyn) begin
         count_q    <= '0;
         load_err_q <= 1'b0;
         prescaler  <= '0;
         idx        <= '0;
         seg_q      <= SEG_RST;
         sel_q      <= SEL_RST;
      end else begin
         count_q    <= count_next;
         load_err_q <= bus.Load & ~din_ok;
         prescaler  <= prescaler_next;
         idx        <= idx_next;
         seg_q      <= (COMMON_ANODE != 0) ? ~decode(scan_digit) : decode(scan_digit);
         sel_q      <= (COMMON_ANODE != 0) ? ~(DIGITS'(1) << idx_next) : (DIGITS'(1) << idx_next);
      end
   end

   assign bus.Q        = count_q;
   assign bus.load_err = load_err_q;
   assign bus.seg      = seg_q;
   assign bus.dig_sel  = sel_q;
   assign bus.tc       = bus.en & ~bus.Load &
                         ((bus.up & all_nine) | (~bus.up & all_zero));

endmodule

// File: tb/tb_bcd_counter_multi.sv
// Self-checking bench: a wrapping and a saturating counter driven in lockstep,
// checked against an integer-arithmetic model, fixed vectors and corner sequences.
module tb_bcd_counter_multi;

   localparam int D    = 4;
   localparam int SD   = 4;
   localparam int MAXV = 9999;

   logic clk = 1'b0;
   logic rst_asyn;
   always #5 clk = ~clk;

   bcd_counter_multi_if #(.DIGITS(D)) bw ();
   bcd_counter_multi_if #(.DIGITS(D)) bs ();

   bcd_counter_multi #(.DIGITS(D), .SCAN_DIV(SD), .SATURATE(0), .COMMON_ANODE(0)) dut_wrap (
      .clk(clk), .rst_asyn(rst_asyn), .bus(bw)
   );
   bcd_counter_multi #(.DIGITS(D), .SCAN_DIV(SD), .SATURATE(1), .COMMON_ANODE(0)) dut_sat (
      .clk(clk), .rst_asyn(rst_asyn), .bus(bs)
   );

   int pass_count  = 0;
   int check_count = 0;

   int         m_val [2];
   bit         m_err [2];
   logic [6:0] m_seg [2];
   logic [3:0] m_sel;
   int         n_edges;

   logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   typedef struct {
      bit          e;
      bit          u;
      bit          l;
      logic [15:0] din;
      logic [15:0] exp_q;
      bit          exp_err;
   } vec_t;

   vec_t vecs [16];

   function automatic int pow10(int n);
      int p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   function automatic logic [15:0] to_bcd(int v);
      logic [15:0] r = '0;
      for (int k = 0; k < D; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
      return r;
   endfunction

   // Returns -1 when any nibble is not a decimal digit.
   function automatic int from_bcd(logic [15:0] b);
      int v = 0;
      for (int k = 0; k < D; k++) begin
         if (b[4*k +: 4] > 4'd9) return -1;
         v = v + int'(b[4*k +: 4]) * pow10(k);
      end
      return v;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      check_count++;
      if (act === exp) pass_count++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic check_dut(string tag, int i, logic [15:0] q, logic err,
                            logic [6:0] seg, logic [3:0] sel);
      check({tag, ".Q"},        q,   to_bcd(m_val[i]));
      check({tag, ".load_err"}, err, m_err[i]);
      check({tag, ".seg"},      seg, m_seg[i]);
      check({tag, ".dig_sel"},  sel, m_sel);
   endtask

   task automatic checkOutput();
      check_dut("wrap", 0, bw.Q, bw.load_err, bw.seg, bw.dig_sel);
      check_dut("sat",  1, bs.Q, bs.load_err, bs.seg, bs.dig_sel);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_val[i] = 0;
         m_err[i] = 1'b0;
         m_seg[i] = 7'h3F;
      end
      m_sel   = 4'b0001;
      n_edges = 0;
   endtask

   task automatic drive(bit e, bit u, bit l, logic [15:0] din);
      bw.en = e; bw.up = u; bw.Load = l; bw.Din = din;
      bs.en = e; bs.up = u; bs.Load = l; bs.Din = din;
   endtask

   // One clock: check tc before the edge, advance the model, check after it.
   task automatic applyStimulus(bit e, bit u, bit l, logic [15:0] din);
      int old_v [2];
      int dv, idx;
      bit exp_tc;
      drive(e, u, l, din);
      #1;
      for (int i = 0; i < 2; i++) begin
         exp_tc = e && !l && ((u && m_val[i] == MAXV) || (!u && m_val[i] == 0));
         check(i == 0 ? "wrap.tc" : "sat.tc", i == 0 ? bw.tc : bs.tc, exp_tc);
      end
      dv = from_bcd(din);
      n_edges++;
      idx = (n_edges / SD) % D;
      for (int i = 0; i < 2; i++) begin
         old_v[i] = m_val[i];
         m_err[i] = 1'b0;
         if (l) begin
            if (dv < 0) m_err[i] = 1'b1;
            else        m_val[i] = dv;
         end else if (e) begin
            if (u) begin
               if (m_val[i] == MAXV) m_val[i] = (i == 1) ? MAXV : 0;
               else                  m_val[i] = m_val[i] + 1;
            end else begin
               if (m_val[i] == 0) m_val[i] = (i == 1) ? 0 : MAXV;
               else               m_val[i] = m_val[i] - 1;
            end
         end
         m_seg[i] = seg_tab[(old_v[i] / pow10(idx)) % 10];
      end
      m_sel = 4'(1 << idx);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic set_vec(int n, bit e, bit u, bit l, logic [15:0] din,
                          logic [15:0] q, bit err);
      vecs[n].e = e; vecs[n].u = u; vecs[n].l = l; vecs[n].din = din;
      vecs[n].exp_q = q; vecs[n].exp_err = err;
   endtask

   initial begin
      set_vec( 0, 0, 0, 1, 16'h0042, 16'h0042, 0);
      set_vec( 1, 0, 0, 1, 16'h9998, 16'h9998, 0);
      set_vec( 2, 1, 1, 0, 16'h0000, 16'h9999, 0);
      set_vec( 3, 1, 1, 0, 16'h0000, 16'h0000, 0);
      set_vec( 4, 1, 1, 0, 16'h0000, 16'h0001, 0);
      set_vec( 5, 0, 0, 1, 16'h0123, 16'h0123, 0);
      set_vec( 6, 0, 0, 1, 16'h12A4, 16'h0123, 1);
      set_vec( 7, 0, 0, 1, 16'hF000, 16'h0123, 1);
      set_vec( 8, 0, 0, 0, 16'h0000, 16'h0123, 0);
      set_vec( 9, 0, 0, 1, 16'h1000, 16'h1000, 0);
      set_vec(10, 1, 0, 0, 16'h0000, 16'h0999, 0);
      set_vec(11, 0, 0, 1, 16'h0000, 16'h0000, 0);
      set_vec(12, 1, 0, 0, 16'h0000, 16'h9999, 0);
      set_vec(13, 1, 1, 1, 16'h0500, 16'h0500, 0);
      set_vec(14, 1, 1, 0, 16'h0000, 16'h0501, 0);
      set_vec(15, 1, 1, 1, 16'h0A00, 16'h0501, 1);

      rst_asyn = 1'b1;
      drive(0, 0, 0, 16'h0000);
      model_reset();
      #7;
      check("reset.Q", bw.Q, 16'h0000);
      check("reset.seg", bw.seg, 7'h3F);
      check("reset.dig_sel", bw.dig_sel, 4'b0001);
      check("reset.load_err", bw.load_err, 1'b0);
      checkOutput();
      @(negedge clk);
      rst_asyn = 1'b0;

      $display("[TB] fixed vectors");
      for (int n = 0; n < 16; n++) begin
         applyStimulus(vecs[n].e, vecs[n].u, vecs[n].l, vecs[n].din);
         check($sformatf("vec%0d.Q", n), bw.Q, vecs[n].exp_q);
         check($sformatf("vec%0d.load_err", n), bw.load_err, vecs[n].exp_err);
      end

      $display("[TB] saturation at both limits");
      applyStimulus(0, 0, 1, 16'h0001);
      applyStimulus(1, 0, 0, 16'h0000);
      check("sat.down_reach", bs.Q, 16'h0000);
      for (int n = 0; n < 5; n++) begin
         #1;
         check("sat.tc_at_zero", bs.tc, 1'b1);
         applyStimulus(1, 0, 0, 16'h0000);
         check("sat.hold_zero", bs.Q, 16'h0000);
      end
      applyStimulus(0, 0, 1, 16'h9999);
      for (int n = 0; n < 3; n++) begin
         applyStimulus(1, 1, 0, 16'h0000);
         check("sat.hold_nine", bs.Q, 16'h9999);
      end

      $display("[TB] scan of 4321");
      applyStimulus(0, 0, 1, 16'h4321);
      for (int n = 0; n < 2 * D * SD; n++) applyStimulus(0, 0, 0, 16'h0000);

      $display("[TB] async reset mid-count");
      applyStimulus(0, 0, 1, 16'h0057);
      applyStimulus(1, 1, 0, 16'h0000);
      applyStimulus(1, 1, 0, 16'h0000);
      check("midrst.before", bw.Q, 16'h0059);
      #2;
      rst_asyn = 1'b1;
      model_reset();
      #1;
      check("midrst.Q", bw.Q, 16'h0000);
      check("midrst.seg", bw.seg, 7'h3F);
      check("midrst.dig_sel", bw.dig_sel, 4'b0001);
      checkOutput();
      #1;
      rst_asyn = 1'b0;
      applyStimulus(1, 1, 0, 16'h0000);
      check("midrst.first_count", bw.Q, 16'h0001);

      $display("[TB] random stimulus");
      for (int n = 0; n < 400; n++) begin
         bit          e, u, l;
         logic [15:0] din;
         int          pick;
         e = ($urandom_range(0, 3) != 0);
         u = $urandom_range(0, 1) != 0;
         l = ($urandom_range(0, 7) == 0);
         pick = $urandom_range(0, 3);
         if (pick == 0)      din = 16'($urandom);
         else if (pick == 1) din = to_bcd($urandom_range(MAXV - 3, MAXV));
         else if (pick == 2) din = to_bcd($urandom_range(0, 3));
         else                din = to_bcd($urandom_range(0, MAXV));
         applyStimulus(e, u, l, din);
      end

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
